// File: rtl/frame_scan_ctrl_if.sv
// frame_scan_ctrl_if: pixel handshake bundle between the scan controller,
// the pixel source (src_*) and the pixel sink (dst_*, row/col tags).
// master = controller side, slave = source/sink environment side.
interface frame_scan_ctrl_if;
  logic        src_valid;
  logic        src_ready;
  logic        dst_valid;
  logic        dst_ready;
  logic [10:0] row;
  logic [10:0] col;

  modport master (
    input  src_valid, dst_ready,
    output src_ready, dst_valid, row, col
  );

  modport slave (
    output src_valid, dst_ready,
    input  src_ready, dst_valid, row, col
  );
endinterface

// File: rtl/frame_scan_ctrl.sv
// frame_scan_ctrl: paces one width x height frame from source to sink through
// a one-entry tagged output register, reporting progress and completion.
// Optional feature macro: SCAN_BOTTOM_UP_EN (rows scanned height-1 down to 0).
module frame_scan_ctrl #(
  parameter int unsigned MAX_DIM = 2048
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic                   start,
  input  logic                   abort,
  input  logic [31:0]            width,
  input  logic [31:0]            height,
  frame_scan_ctrl_if.master      bus,
  output logic [22:0]            pixel_count,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t      state_q, state_d;
  logic [10:0] col_last;     // width - 1
  logic [22:0] total;        // width * height
  logic [10:0] nrow, ncol;   // coordinate of the next pixel to accept
  logic [10:0] row_q, col_q;
  logic        dst_valid_q;
  logic        src_ready;
  logic        accept;
  logic        last;
  logic        legal;
  logic        err_q;

  assign legal = (width != '0) && (width <= MAX_DIM) &&
                 (height != '0) && (height <= MAX_DIM);
  assign last  = (pixel_count + 23'd1) == total;

  assign bus.src_ready = src_ready;
  assign bus.dst_valid = dst_valid_q;
  assign bus.row       = row_q;
  assign bus.col       = col_q;
  assign err           = err_q;

  // State register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state, source handshake and status decode
  always_comb begin
    state_d   = state_q;
    src_ready = 1'b0;
    accept    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && legal) state_d = SCAN;
      end
      SCAN: begin
        busy      = 1'b1;
        src_ready = !dst_valid_q || bus.dst_ready;
        accept    = bus.src_valid && src_ready;
        if (accept && last) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (!dst_valid_q || bus.dst_ready) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      accept  = 1'b0;
    end
  end

  // Frame size latch, coordinate counter, output register and progress count
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      col_last    <= '0;
      total       <= '0;
      nrow        <= '0;
      ncol        <= '0;
      row_q       <= '0;
      col_q       <= '0;
      dst_valid_q <= 1'b0;
      pixel_count <= '0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (abort) begin
        dst_valid_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              if (legal) begin
                // width up to 2048 wraps to 0 in 11 bits, so width-1 is exact
                col_last    <= 11'(width - 32'd1);
                total       <= 23'(width * height);
                pixel_count <= '0;
                ncol        <= '0;
`ifdef SCAN_BOTTOM_UP_EN
                nrow        <= 11'(height - 32'd1);
`else
                nrow        <= '0;
`endif
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          SCAN: begin
            if (accept) begin
              row_q       <= nrow;
              col_q       <= ncol;
              dst_valid_q <= 1'b1;
              pixel_count <= pixel_count + 23'd1;
              if (ncol == col_last) begin
                ncol <= '0;
`ifdef SCAN_BOTTOM_UP_EN
                nrow <= nrow - 11'd1;
`else
                nrow <= nrow + 11'd1;
`endif
              end else begin
                ncol <= ncol + 11'd1;
              end
            end else if (bus.dst_ready) begin
              dst_valid_q <= 1'b0;
            end
          end
          DRAIN: begin
            if (bus.dst_ready) dst_valid_q <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_scan_ctrl.sv
// tb_frame_scan_ctrl: randomized and directed frames checked against a
// row-major tag model built from the frame size alone.
module tb_frame_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] width = '0;
  logic [31:0] height = '0;
  logic [22:0] pixel_count;
  logic        busy, done, err;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  frame_scan_ctrl_if bus ();

  frame_scan_ctrl #(.MAX_DIM(2048)) dut (
    .HCLK        (clk),
    .HRESETn     (rst_n),
    .start       (start),
    .abort       (abort),
    .width       (width),
    .height      (height),
    .bus         (bus),
    .pixel_count (pixel_count),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full frame; the model lists tags in scan order from w/h only.
  task automatic run_frame(input int unsigned w, input int unsigned h, input bit rnd,
                           input int unsigned stall_at, input int unsigned stall_len,
                           input bit poke);
    logic [21:0] exp_q[$];
    logic [21:0] held;
    int unsigned got = 0, acc = 0, cyc = 0, budget;
    int unsigned n_done = 0, n_err = 0, bad_ready = 0, bad_hold = 0;
    bit was_stalled = 0;
    budget = w * h * 16 + 40;
    for (int unsigned i = 0; i < w * h; i++) begin
      int unsigned r;
      r = i / w;
`ifdef SCAN_BOTTOM_UP_EN
      r = h - 1 - r;
`endif
      exp_q.push_back({11'(r), 11'(i % w)});
    end

    start = 1'b1; width = w; height = h;
    bus.src_valid = 1'b0; bus.dst_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_on", busy, 1);
    check("src_ready_on", bus.src_ready, 1);

    while (got < w * h && cyc < budget) begin
      if (rnd) begin
        bus.src_valid = ($urandom_range(0, 3) != 0);
        bus.dst_ready = ($urandom_range(0, 3) != 0);
      end else begin
        bus.src_valid = 1'b1;
        bus.dst_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      end
      start = poke && (cyc == 2);
      if (start) begin width = 7; height = 7; end
      else       begin width = w; height = h; end

      @(negedge clk);
      if (done) n_done++;
      if (err)  n_err++;
      check("pixel_count", pixel_count, acc);
      if (was_stalled && (!bus.dst_valid || {bus.row, bus.col} !== held)) bad_hold++;
      if (bus.dst_valid && !bus.dst_ready && bus.src_ready) bad_ready++;
      was_stalled = bus.dst_valid && !bus.dst_ready;
      held = {bus.row, bus.col};
      if (bus.src_valid && bus.src_ready) acc++;
      if (bus.dst_valid && bus.dst_ready) begin
        check("tag", {10'd0, bus.row, bus.col}, {10'd0, exp_q[got]});
        got++;
      end
      @(posedge clk); #1;
      cyc++;
    end

    check("frame_complete", got, w * h);
    check("accepted", acc, w * h);
    if (!rnd) check("throughput", cyc, w * h + 1 + stall_len);
    check("done_pulse", done, 1);
    check("busy_off", busy, 0);
    check("pixel_count_end", pixel_count, w * h);
    check("early_done", n_done, 0);
    check("err_quiet", n_err, 0);
    check("stall_ready", bad_ready, 0);
    check("stall_hold", bad_hold, 0);
    bus.src_valid = 1'b0; bus.dst_ready = 1'b0;
    @(posedge clk); #1;
    check("done_once", done, 0);
    check("idle_ready", bus.src_ready, 0);
  endtask

  task automatic bad_start(input logic [31:0] w, input logic [31:0] h, input string tag);
    start = 1'b1; width = w; height = h;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_err"}, err, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ready"}, bus.src_ready, 0);
    @(posedge clk); #1;
    check({tag, "_err_pulse"}, err, 0);
    check({tag, "_busy2"}, busy, 0);
  endtask

  task automatic abort_frame();
    int unsigned acc = 0, cyc = 0, n_done = 0;
    start = 1'b1; width = 4; height = 4;
    @(posedge clk); #1;
    start = 1'b0;
    bus.src_valid = 1'b1; bus.dst_ready = 1'b1;
    while (acc < 5 && cyc < 40) begin
      @(negedge clk);
      if (bus.src_valid && bus.src_ready) acc++;
      @(posedge clk); #1;
      cyc++;
    end
    check("abort_reach5", acc, 5);
    abort = 1'b1; bus.src_valid = 1'b0; bus.dst_ready = 1'b0;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_dst_valid", bus.dst_valid, 0);
    check("abort_ready", bus.src_ready, 0);
    check("abort_count", pixel_count, 5);
    for (int i = 0; i < 4; i++) begin
      if (done) n_done++;
      @(posedge clk); #1;
    end
    check("abort_no_done", n_done, 0);
  endtask

  task automatic async_reset_mid_frame();
    int unsigned n_done = 0;
    start = 1'b1; width = 3; height = 3;
    @(posedge clk); #1;
    start = 1'b0;
    bus.src_valid = 1'b1; bus.dst_ready = 1'b1;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("areset_dst_valid", bus.dst_valid, 0);
    check("areset_busy", busy, 0);
    check("areset_count", pixel_count, 0);
    check("areset_tag", {10'd0, bus.row, bus.col}, 0);
    bus.src_valid = 1'b0; bus.dst_ready = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (done || busy) n_done++;
      @(posedge clk); #1;
    end
    check("areset_no_done", n_done, 0);
  endtask

  initial begin
    bus.src_valid = 1'b0;
    bus.dst_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_src_ready", bus.src_ready, 0);
    check("rst_dst_valid", bus.dst_valid, 0);
    check("rst_tag", {10'd0, bus.row, bus.col}, 0);
    check("rst_count", pixel_count, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_frame(4, 2, 0, 0, 0, 0);
    run_frame(3, 3, 0, 3, 5, 0);
    bad_start(32'd0, 32'd4, "zero_width");
    bad_start(32'd4, 32'd2049, "big_height");
    abort_frame();
    run_frame(2, 2, 0, 0, 0, 0);
    run_frame(3, 2, 0, 0, 0, 1);
    run_frame(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      run_frame($urandom_range(1, 6), $urandom_range(1, 6), 1, 0, 0, 0);
    run_frame(2048, 1, 1, 0, 0, 0);
    run_frame(1, 5, 1, 0, 0, 0);
    async_reset_mid_frame();
    run_frame(3, 2, 1, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/frame_scan_ctrl.md
# frame_scan_ctrl

Frame-level scan controller between the pixel source (`image_read` side) and the pixel sink (`image_write` side). On a start pulse it latches the frame size and then paces the transfer of exactly width×height pixels with valid/ready handshakes on both sides, tagging each pixel with its row/col coordinate. It holds a one-entry output register, reports progress, and pulses `done` when the last pixel has been accepted by the sink.

## Interface
- `MAX_DIM`, 2048: largest legal width or height; a frame is legal when 1 ≤ width, height ≤ MAX_DIM.
- `HCLK`  in  1  clock; all state changes on the rising edge.
- `HRESETn`  in  1  asynchronous reset, active-low.
- `start`  in  1  frame start request; sampled only in IDLE.
- `abort`  in  1  synchronous abort; return to IDLE from any state.
- `width`  in  32  frame width in pixels; sampled together with `start`.
- `height`  in  32  frame height in pixels; sampled together with `start`.
- `src_valid`  in  1  source presents a pixel.
- `src_ready`  out  1  controller accepts a source pixel this cycle.
- `dst_valid`  out  1  output register holds a tagged pixel.
- `dst_ready`  in  1  sink consumes the output pixel this cycle.
- `row`  out  11  row tag of the pixel in the output register.
- `col`  out  11  column tag of the pixel in the output register.
- `pixel_count`  out  23  pixels accepted from the source in the current frame.
- `busy`  out  1  high in SCAN and DRAIN.
- `done`  out  1  one-cycle pulse at frame completion.
- `err`  out  1  one-cycle pulse when `start` arrives with an illegal size.

## Operation
- States: IDLE, SCAN, DRAIN, DONE.
- IDLE: `src_ready`=0. On `start`: if size legal, latch width/height, clear `pixel_count`, load the next-coordinate counter with col=0 and the first row, go to SCAN; otherwise pulse `err` and stay in IDLE.
- SCAN: `src_ready` = !`dst_valid` || `dst_ready`. Accept = `src_valid` && `src_ready`. On accept: the output register loads the next coordinate, `dst_valid`←1, `pixel_count`+1, coordinate advances. When no accept and `dst_ready` is high, `dst_valid`←0.
- Coordinate advance: col+1; at col = width−1, col←0 and row steps to the next row (see Configuration).
- When the accepted pixel is the last one (`pixel_count` reaches width×height): go to DRAIN.
- DRAIN: `src_ready`=0; leave for DONE when `dst_valid` is 0, or when `dst_ready` is high and clears it.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `start` outside IDLE is ignored; it does not produce `err`.
- `abort` has priority over everything except reset: next state IDLE, `dst_valid`←0, no `done` pulse. `pixel_count` holds its value.
- Width×height uses a 23-bit product; the MAX_DIM check is made on the full 32-bit inputs before truncation.

## Timing
- Reset values: `src_ready`=0, `dst_valid`=0, `row`=0, `col`=0, `pixel_count`=0, `busy`=0, `done`=0, `err`=0; state IDLE.
- `start` sampled at edge 0 → SCAN and `src_ready`=1 from cycle 1.
- Latency: a pixel accepted at edge k shows `dst_valid`=1 with its tags from edge k until the sink takes it.
- Throughput: one pixel per clock while `src_valid` and `dst_ready` are both high.
- If `dst_ready` is low, `dst_valid`, `row` and `col` hold steady.
- `done` is asserted on the edge after the sink consumes the final pixel. `busy` falls on the same edge.
- `err` is asserted one cycle after the offending `start`.
- An asynchronous reset mid-frame forces all reset values immediately. No completion is reported for that frame.

## Configuration
- `SCAN_BOTTOM_UP_EN` defined: the first row is height−1 and row decrements, matching BMP row storage order. The last pixel is row 0, col width−1.
- `SCAN_BOTTOM_UP_EN` undefined: the first row is 0 and row increments. The last pixel is row height−1, col width−1.

## Test plan
- 4×2 frame, `src_valid`=`dst_ready`=1, macro off → 8 pixels with tags (0,0)…(0,3),(1,0)…(1,3) on consecutive cycles; `pixel_count`=8; `done` pulses once, 1 cycle after the last transfer.
- Same frame with macro on → tag order (1,0)…(1,3),(0,0)…(0,3).
- 3×3 frame, `dst_ready` low for 5 cycles mid-frame → `src_ready`=0 while `dst_valid` is stalled; tags stable; no pixel lost or duplicated; 9 transfers total.
- `start` with width=0, then with height=MAX_DIM+1 → `err` pulse each time, `busy` stays 0, no `src_ready`.
- `abort` after 5 of 16 pixels of a 4×4 frame → IDLE next cycle, `dst_valid`=0, no `done`; a new 2×2 start then completes normally with 4 pixels.
- `start` pulsed during SCAN → ignored; the frame completes with the original size; `err` stays 0.
